vote_collector: RTL and testbench
=================================

Name: vote_collector

Overview:
Sequential front end for the weighted vote tally. It runs one voting session, accepting one ballot per cycle from a serial ballot bus. It assembles the 32-bit normal-voter bitmap, the 8-bit VIP bitmap and the VVIP bit, maintains a running weighted tally, and rejects duplicate or malformed ballots. When the session closes it latches and holds the pass/fail result.

Parameters:
NP_N, 32, number of normal voters (ids 0..NP_N-1)
VIP_N, 8, number of VIP voters (ids 0..VIP_N-1)
VIP_W, 4, weight of one VIP yes-vote (normal weight is fixed at 1)
VVIP_W, 16, weight of the VVIP yes-vote
THRESH, 32, tally at or above which the motion passes

Ports:
clk  in  1  system clock, all state updates on the rising edge
reset  in  1  asynchronous, active-high; clears all state
start  in  1  open a new session (honoured in IDLE and CLOSED)
close  in  1  close the current session (honoured in OPEN)
ballot_valid  in  1  ballot present this cycle
ballot_class  in  2  0 = normal, 1 = VIP, 2 = VVIP, 3 = illegal
ballot_id  in  5  voter index within its class (ignored for VVIP)
ballot_yes  in  1  1 = yes vote, 0 = explicit no vote
ballot_ready  out  1  1 while in OPEN
np  out  32  registered yes-bitmap of normal voters
vip  out  8  registered yes-bitmap of VIP voters
vvip  out  1  registered VVIP yes-bit
tally  out  7  registered weighted yes-count (max 32+32+16=80)
res  out  1  registered: tally >= THRESH, tracked live
done  out  1  1 while in CLOSED
dup_err  out  1  one-cycle pulse: voter already voted, ballot discarded
inv_err  out  1  one-cycle pulse: illegal class or id out of range, ballot discarded

Behaviour:
- Reset (asynchronous, active-high): state goes to IDLE. np, vip, vvip, tally, res, done, dup_err, inv_err and ballot_ready all go to 0. The internal cast-bitmaps are cleared.
- The FSM has three states: IDLE, OPEN and CLOSED.
- IDLE:
  - ballots are ignored, with no error pulses.
  - start moves to OPEN and clears np, vip, vvip, tally, res and the cast-bitmaps on the same edge.
- OPEN:
  - ballot_ready = 1.
  - A ballot is accepted on any edge where ballot_valid = 1.
- Legal ballot from a voter not yet cast:
  - set that voter's cast bit.
  - if ballot_yes = 1, also set its yes bit and add the weight to tally (1, VIP_W or VVIP_W).
  - all outputs reflect the ballot one edge after acceptance; res = (tally_next >= THRESH) on that same edge.
- Explicit no vote: still consumes the voter's single vote. A later yes from the same voter raises dup_err.
- Repeat ballot from a voter whose cast bit is set: no state change; dup_err = 1 for exactly one cycle after the edge.
- Illegal ballot (class 3, normal id >= NP_N, or VIP id >= VIP_N): no state change; inv_err pulses. inv_err takes priority over dup_err, so both never fire together.
- close in OPEN moves to CLOSED.
  - If ballot_valid is high on the same edge, the ballot is processed first and counts.
  - In CLOSED, done = 1 and np/vip/vvip/tally/res are frozen.
- start in OPEN is ignored. start and close together in OPEN: close wins.
- CLOSED:
  - ballots are ignored, with no errors.
  - start re-enters OPEN with all cleared state, as from IDLE.
- Width rules:
  - tally uses unsigned 7-bit arithmetic. It cannot overflow: the maximum is 80 with default parameters, and the width must be at least clog2(NP_N + VIP_N*VIP_W + VVIP_W + 1).
  - The comparison with THRESH is unsigned.
- Reset during OPEN discards the partial session; no result is produced.

Decomposition:
- Shared package (vote_pkg) holds:
  - class encodings CLS_NP = 0, CLS_VIP = 1, CLS_VVIP = 2.
  - default weights and THRESH.
  - state encoding S_IDLE, S_OPEN, S_CLOSED.
  - the tally-width function.
- One natural sub-module: vote_ballot_check. It is combinational: from class, id and the cast-bitmaps it produces legal, dup and weight. The FSM and registers stay in vote_collector.

Test Plan:
- reset, start, then 32 normal yes ballots ids 0..31 -> np = 0xFFFFFFFF, tally = 32, res = 1 on the edge after id 31; close -> done = 1, res held at 1.
- start; VVIP yes, then VIP ids 0..3 yes -> tally = 32, res = 1; VIP id 4 yes then VIP id 4 no -> tally = 36, dup_err pulses once, vip = 0x1F.
- start; normal id 7 no, then normal id 7 yes -> np[7] = 0, tally = 0, dup_err = 1 for one cycle.
- start; class 3 ballot, then VIP id 9 -> inv_err pulses twice, no state change, tally = 0.
- start; 31 normal yes ballots with close asserted together with the 31st ballot -> 31st counted, tally = 31, res = 0, done = 1; further ballots ignored, no errors.
- mid-session (tally = 20), assert reset asynchronously between clock edges -> all outputs 0 immediately, state IDLE; start then begins with tally = 0.

Source files
------------

// File: rtl/vote_pkg.sv
// vote_pkg: shared class/state encodings, default weights and tally sizing for the vote collector
package vote_pkg;
  localparam logic [1:0] CLS_NP = 2'd0;
  localparam logic [1:0] CLS_VIP = 2'd1;
  localparam logic [1:0] CLS_VVIP = 2'd2;
  localparam int NP_N_DEF = 32;
  localparam int VIP_N_DEF = 8;
  localparam int VIP_W_DEF = 4;
  localparam int VVIP_W_DEF = 16;
  localparam int THRESH_DEF = 32;
  typedef enum logic [1:0] {S_IDLE, S_OPEN, S_CLOSED} state_t;
  function automatic int tally_w(input int np_n, input int vip_n, input int vip_w, input int vvip_w);
    return $clog2(np_n + vip_n * vip_w + vvip_w + 1);
  endfunction
endpackage

// File: rtl/vote_ballot_check.sv
// vote_ballot_check: classifies one ballot as legal/duplicate and yields its yes-weight
module vote_ballot_check
  import vote_pkg::*;
#(
  parameter int NP_N = NP_N_DEF,
  parameter int VIP_N = VIP_N_DEF,
  parameter int VIP_W = VIP_W_DEF,
  parameter int VVIP_W = VVIP_W_DEF,
  parameter int TW = 7
) (
  input  logic [1:0]       cls,
  input  logic [4:0]       id,
  input  logic [NP_N-1:0]  np_cast,
  input  logic [VIP_N-1:0] vip_cast,
  input  logic             vvip_cast,
  output logic             legal,
  output logic             dup,
  output logic [TW-1:0]    weight
);
  localparam int NB = $clog2(NP_N);
  localparam int VB = $clog2(VIP_N);
  always_comb begin
    legal = cls == CLS_NP ? 32'(id) < NP_N : cls == CLS_VIP ? 32'(id) < VIP_N : cls == CLS_VVIP;
    dup = cls == CLS_NP ? np_cast[id[NB-1:0]] : cls == CLS_VIP ? vip_cast[id[VB-1:0]] : vvip_cast;
    weight = cls == CLS_NP ? TW'(1) : cls == CLS_VIP ? TW'(VIP_W) : TW'(VVIP_W);
  end
endmodule

// File: rtl/vote_collector.sv
// vote_collector: single-session ballot FSM with yes-bitmaps, weighted tally and latched result
module vote_collector
  import vote_pkg::*;
#(
  parameter int NP_N = NP_N_DEF,
  parameter int VIP_N = VIP_N_DEF,
  parameter int VIP_W = VIP_W_DEF,
  parameter int VVIP_W = VVIP_W_DEF,
  parameter int THRESH = THRESH_DEF,
  localparam int TW = tally_w(NP_N, VIP_N, VIP_W, VVIP_W)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             close,
  input  logic             ballot_valid,
  input  logic [1:0]       ballot_class,
  input  logic [4:0]       ballot_id,
  input  logic             ballot_yes,
  output logic             ballot_ready,
  output logic [NP_N-1:0]  np,
  output logic [VIP_N-1:0] vip,
  output logic             vvip,
  output logic [TW-1:0]    tally,
  output logic             res,
  output logic             done,
  output logic             dup_err,
  output logic             inv_err
);
  localparam int NB = $clog2(NP_N);
  localparam int VB = $clog2(VIP_N);
  state_t state_q, state_d;
  logic [NP_N-1:0] np_q, np_d, npc_q, npc_d;
  logic [VIP_N-1:0] vip_q, vip_d, vipc_q, vipc_d;
  logic vvip_q, vvip_d, vvipc_q, vvipc_d;
  logic [TW-1:0] tally_q, tally_d, weight;
  logic res_q, res_d, dup_q, dup_d, inv_q, inv_d, legal, dup;
  vote_ballot_check #(.NP_N(NP_N), .VIP_N(VIP_N), .VIP_W(VIP_W), .VVIP_W(VVIP_W), .TW(TW)) u_check (
    .cls(ballot_class), .id(ballot_id), .np_cast(npc_q), .vip_cast(vipc_q), .vvip_cast(vvipc_q),
    .legal(legal), .dup(dup), .weight(weight)
  );
  always_comb begin
    state_d = state_q;
    np_d = np_q;
    vip_d = vip_q;
    vvip_d = vvip_q;
    npc_d = npc_q;
    vipc_d = vipc_q;
    vvipc_d = vvipc_q;
    tally_d = tally_q;
    res_d = res_q;
    dup_d = 1'b0;
    inv_d = 1'b0;
    if (state_q != S_OPEN && start) begin
      state_d = S_OPEN;
      np_d = '0;
      vip_d = '0;
      vvip_d = 1'b0;
      npc_d = '0;
      vipc_d = '0;
      vvipc_d = 1'b0;
      tally_d = '0;
      res_d = 1'b0;
    end else if (state_q == S_OPEN) begin
      state_d = close ? S_CLOSED : S_OPEN;
      if (ballot_valid && !legal) inv_d = 1'b1;
      else if (ballot_valid && dup) dup_d = 1'b1;
      else if (ballot_valid) begin
        if (ballot_class == CLS_NP) begin
          npc_d[ballot_id[NB-1:0]] = 1'b1;
          np_d[ballot_id[NB-1:0]] = ballot_yes;
        end else if (ballot_class == CLS_VIP) begin
          vipc_d[ballot_id[VB-1:0]] = 1'b1;
          vip_d[ballot_id[VB-1:0]] = ballot_yes;
        end else begin
          vvipc_d = 1'b1;
          vvip_d = ballot_yes;
        end
        tally_d = ballot_yes ? tally_q + weight : tally_q;
      end
      res_d = tally_d >= TW'(THRESH);
    end
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      np_q <= '0;
      vip_q <= '0;
      vvip_q <= 1'b0;
      npc_q <= '0;
      vipc_q <= '0;
      vvipc_q <= 1'b0;
      tally_q <= '0;
      res_q <= 1'b0;
      dup_q <= 1'b0;
      inv_q <= 1'b0;
    end else begin
      state_q <= state_d;
      np_q <= np_d;
      vip_q <= vip_d;
      vvip_q <= vvip_d;
      npc_q <= npc_d;
      vipc_q <= vipc_d;
      vvipc_q <= vvipc_d;
      tally_q <= tally_d;
      res_q <= res_d;
      dup_q <= dup_d;
      inv_q <= inv_d;
    end
  end
  assign ballot_ready = state_q == S_OPEN;
  assign done = state_q == S_CLOSED;
  assign np = np_q;
  assign vip = vip_q;
  assign vvip = vvip_q;
  assign tally = tally_q;
  assign res = res_q;
  assign dup_err = dup_q;
  assign inv_err = inv_q;
endmodule

// File: tb/tb_vote_collector.sv
// tb_vote_collector: directed ballot sequences checked against a queued reference model
module tb_vote_collector;
  logic clk = 1'b0, reset = 1'b1, start = 1'b0, close = 1'b0;
  logic ballot_valid = 1'b0, ballot_yes = 1'b0;
  logic [1:0] ballot_class = 2'd0;
  logic [4:0] ballot_id = 5'd0;
  logic ballot_ready, vvip, res, done, dup_err, inv_err;
  logic [31:0] np;
  logic [7:0] vip;
  logic [6:0] tally;
  int errors = 0, checks = 0;
  typedef struct packed {
    logic [31:0] np;
    logic [7:0] vip;
    logic vvip;
    logic [6:0] tally;
    logic res, done, ready, dup, inv;
  } exp_t;
  exp_t sb[$];
  int ms = 0;
  logic [31:0] m_np, m_npc;
  logic [7:0] m_vip, m_vipc;
  logic m_vvip, m_vvipc, m_res, m_dup, m_inv;
  int m_tally;
  vote_collector dut (
    .clk(clk), .reset(reset), .start(start), .close(close), .ballot_valid(ballot_valid),
    .ballot_class(ballot_class), .ballot_id(ballot_id), .ballot_yes(ballot_yes),
    .ballot_ready(ballot_ready), .np(np), .vip(vip), .vvip(vvip), .tally(tally), .res(res),
    .done(done), .dup_err(dup_err), .inv_err(inv_err)
  );
  always #5 clk = ~clk;
  task automatic cmp(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic model_clear();
    m_np = 0; m_npc = 0; m_vip = 0; m_vipc = 0; m_vvip = 0; m_vvipc = 0;
    m_tally = 0; m_res = 0; m_dup = 0; m_inv = 0;
  endtask
  task automatic model_push();
    exp_t e;
    e.np = m_np; e.vip = m_vip; e.vvip = m_vvip; e.tally = 7'(m_tally); e.res = m_res;
    e.done = ms == 2; e.ready = ms == 1; e.dup = m_dup; e.inv = m_inv;
    sb.push_back(e);
  endtask
  task automatic model(input logic v, input int cls, input int id, input logic yes, input logic st, input logic cl);
    logic legal, cast;
    m_dup = 0; m_inv = 0;
    if (ms != 1 && st) begin
      model_clear();
      ms = 1;
    end else if (ms == 1) begin
      legal = (cls == 0 && id < 32) || (cls == 1 && id < 8) || cls == 2;
      if (v) begin
        cast = cls == 0 ? m_npc[id] : cls == 1 ? m_vipc[id % 8] : m_vvipc;
        if (!legal) m_inv = 1;
        else if (cast) m_dup = 1;
        else begin
          if (cls == 0) begin m_npc[id] = 1; m_np[id] = yes; end
          else if (cls == 1) begin m_vipc[id] = 1; m_vip[id] = yes; end
          else begin m_vvipc = 1; m_vvip = yes; end
          if (yes) m_tally += cls == 0 ? 1 : cls == 1 ? 4 : 16;
        end
      end
      m_res = m_tally >= 32;
      if (cl) ms = 2;
    end
  endtask
  task automatic check_outputs(input exp_t e);
    cmp("np", np, e.np);
    cmp("vip", {24'd0, vip}, {24'd0, e.vip});
    cmp("vvip", {31'd0, vvip}, {31'd0, e.vvip});
    cmp("tally", {25'd0, tally}, {25'd0, e.tally});
    cmp("res", {31'd0, res}, {31'd0, e.res});
    cmp("done", {31'd0, done}, {31'd0, e.done});
    cmp("ready", {31'd0, ballot_ready}, {31'd0, e.ready});
    cmp("dup_err", {31'd0, dup_err}, {31'd0, e.dup});
    cmp("inv_err", {31'd0, inv_err}, {31'd0, e.inv});
  endtask
  task automatic step(input logic v, input int cls, input int id, input logic yes, input logic st, input logic cl);
    ballot_valid = v; ballot_class = 2'(cls); ballot_id = 5'(id); ballot_yes = yes;
    start = st; close = cl;
    model(v, cls, id, yes, st, cl);
    model_push();
    @(posedge clk);
    #1;
    ballot_valid = 0; start = 0; close = 0;
    cmp("sb_nonempty", 32'(sb.size() > 0), 32'd1);
    if (sb.size() > 0) check_outputs(sb.pop_front());
  endtask
  initial begin
    model_clear();
    #12;
    model_push();
    check_outputs(sb.pop_front());
    reset = 0;
    @(posedge clk);
    #1;
    step(0, 0, 0, 0, 1, 0);
    for (int i = 0; i < 32; i++) begin
      step(1, 0, i, 1, 0, 0);
      if (i == 30) cmp("res_below", {31'd0, res}, 32'd0);
    end
    cmp("np_full", np, 32'hFFFFFFFF);
    cmp("tally32", {25'd0, tally}, 32'd32);
    cmp("res_at", {31'd0, res}, 32'd1);
    step(0, 0, 0, 0, 0, 1);
    cmp("done_close", {31'd0, done}, 32'd1);
    cmp("res_held", {31'd0, res}, 32'd1);
    step(0, 0, 0, 0, 1, 0);
    step(1, 2, 0, 1, 0, 0);
    for (int i = 0; i < 4; i++) step(1, 1, i, 1, 0, 0);
    cmp("tally_vip32", {25'd0, tally}, 32'd32);
    cmp("res_vip", {31'd0, res}, 32'd1);
    step(1, 1, 4, 1, 0, 0);
    step(1, 1, 4, 0, 0, 0);
    cmp("dup_vip", {31'd0, dup_err}, 32'd1);
    step(0, 0, 0, 0, 0, 0);
    cmp("dup_vip_once", {31'd0, dup_err}, 32'd0);
    cmp("tally36", {25'd0, tally}, 32'd36);
    cmp("vip1f", {24'd0, vip}, 32'h1F);
    step(0, 0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 1, 0);
    step(1, 0, 7, 0, 0, 0);
    step(1, 0, 7, 1, 0, 0);
    cmp("dup_no", {31'd0, dup_err}, 32'd1);
    cmp("np7", {31'd0, np[7]}, 32'd0);
    step(0, 0, 0, 0, 0, 0);
    cmp("dup_no_once", {31'd0, dup_err}, 32'd0);
    cmp("tally_no", {25'd0, tally}, 32'd0);
    step(0, 0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 1, 0);
    step(1, 3, 2, 1, 0, 0);
    cmp("inv_cls3", {30'd0, inv_err, dup_err}, 32'd2);
    step(1, 1, 9, 1, 0, 0);
    cmp("inv_vip9", {30'd0, inv_err, dup_err}, 32'd2);
    cmp("tally_inv", {25'd0, tally}, 32'd0);
    step(0, 0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 1, 0);
    for (int i = 0; i < 31; i++) step(1, 0, i, 1, i == 10, i == 30);
    cmp("tally31", {25'd0, tally}, 32'd31);
    cmp("res31", {31'd0, res}, 32'd0);
    cmp("done31", {31'd0, done}, 32'd1);
    step(1, 0, 31, 1, 0, 0);
    step(1, 3, 0, 1, 0, 0);
    cmp("closed_tally", {25'd0, tally}, 32'd31);
    cmp("closed_err", {30'd0, inv_err, dup_err}, 32'd0);
    step(0, 0, 0, 0, 1, 0);
    for (int i = 0; i < 20; i++) step(1, 0, i, 1, 0, 0);
    cmp("tally20", {25'd0, tally}, 32'd20);
    #2;
    reset = 1;
    #1;
    ms = 0;
    model_clear();
    model_push();
    check_outputs(sb.pop_front());
    cmp("rst_tally", {25'd0, tally}, 32'd0);
    @(posedge clk);
    #2;
    reset = 0;
    @(posedge clk);
    #1;
    step(1, 0, 3, 1, 0, 0);
    cmp("idle_ignore", {25'd0, tally}, 32'd0);
    step(0, 0, 0, 0, 1, 0);
    step(1, 0, 0, 1, 0, 0);
    cmp("restart_tally", {25'd0, tally}, 32'd1);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
